// File: rtl/fp32_pkg.sv
// Shared fp32 constants, FSM state encoding and operand class codes for the
// float-to-integer conversion path.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] BIAS      = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
  // Smallest exponent whose magnitude reaches 2^31.
  localparam logic [EXP_W-1:0] EXP_SAT   = 8'd158;
  // Exponent at which the hidden-1 mantissa is already an integer (shift 0).
  localparam logic [EXP_W-1:0] EXP_ALIGN = 8'd150;

  localparam logic [31:0] INT_MAX    = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN    = 32'h80000000;
  localparam logic [31:0] FP_INT_MIN = 32'hCF000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    ZERO_SMALL = 3'd1,
    INF        = 3'd2,
    NAN        = 3'd3,
    OVF        = 3'd4
  } class_t;

endpackage

// File: rtl/fp32_to_int32_if.sv
// Operand/result bus of the fp32 -> int32 converter.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the sender holds its payload and valid stable until that edge.
interface fp32_to_int32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        inv;
  logic        inexact;

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, y, ovf, inv, inexact
  );

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, y, ovf, inv, inexact
  );
endinterface

// File: rtl/fp32_classify.sv
// Combinational fp32 field unpack: operand class plus the shift count and
// direction needed to denormalize the hidden-1 mantissa into an integer.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  output class_t      cls,
  output logic        sign,
  output logic        mag_nz,
  output logic        is_int_min,
  output logic [31:0] mant,
  output logic [4:0]  cnt,
  output logic        dir_left
);

  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] frac;

  always_comb begin
    sign       = a[31];
    e          = a[30:23];
    frac       = a[22:0];
    mag_nz     = |a[30:0];
    is_int_min = (a == FP_INT_MIN);
    mant       = {8'b0, 1'b1, frac};
    dir_left   = (e >= EXP_ALIGN);
    // Normal exponents span 127..157, so |e-150| fits in 5 bits and modulo-32
    // arithmetic on the low exponent bits is exact.
    cnt = dir_left ? (e[4:0] - EXP_ALIGN[4:0]) : (EXP_ALIGN[4:0] - e[4:0]);

    if (e == EXP_MAX)      cls = (|frac) ? NAN : INF;
    else if (e < BIAS)     cls = ZERO_SMALL;
    else if (e >= EXP_SAT) cls = OVF;
    else                   cls = NORMAL;
  end

endmodule

// File: rtl/fp32_to_int32.sv
// Iterative fp32 -> int32 converter: truncates toward zero, saturates out-of-range
// inputs, and denormalizes the mantissa STEP bits per cycle.
module fp32_to_int32
  import fp32_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fp32_to_int32_if.slave          bus,
  output state_t                  state_dbg
);

  state_t      state;
  logic [31:0] m;
  logic [4:0]  cnt;
  logic        dir_left;
  logic        sign_q;
  logic        sticky;
  logic [31:0] y_q;
  logic        ovf_q, inv_q, inexact_q, out_valid_q;

  class_t      c_cls;
  logic        c_sign, c_mag_nz, c_is_int_min, c_dir_left;
  logic [31:0] c_mant;
  logic [4:0]  c_cnt;

  fp32_classify u_classify (
    .a          (bus.a),
    .cls        (c_cls),
    .sign       (c_sign),
    .mag_nz     (c_mag_nz),
    .is_int_min (c_is_int_min),
    .mant       (c_mant),
    .cnt        (c_cnt),
    .dir_left   (c_dir_left)
  );

  logic [4:0]  k;
  logic [4:0]  cnt_next;
  logic [31:0] m_next;
  logic [31:0] lost_mask;
  logic        lost;

  always_comb begin
    k         = (cnt < STEP[4:0]) ? cnt : STEP[4:0];
    cnt_next  = cnt - k;
    m_next    = dir_left ? (m << k) : (m >> k);
    lost_mask = (32'd1 << k) - 32'd1;
    lost      = ~dir_left & (|(m & lost_mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      m           <= '0;
      cnt         <= '0;
      dir_left    <= 1'b0;
      sign_q      <= 1'b0;
      sticky      <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m        <= c_mant;
            cnt      <= c_cnt;
            dir_left <= c_dir_left;
            sign_q   <= c_sign;
            sticky   <= 1'b0;
            case (c_cls)
              NAN: begin
                y_q <= INT_MAX; ovf_q <= 1'b0; inv_q <= 1'b1; inexact_q <= 1'b0;
                out_valid_q <= 1'b1; state <= DONE;
              end
              INF: begin
                y_q <= c_sign ? INT_MIN : INT_MAX;
                ovf_q <= 1'b1; inv_q <= 1'b0; inexact_q <= 1'b0;
                out_valid_q <= 1'b1; state <= DONE;
              end
              ZERO_SMALL: begin
                y_q <= '0; ovf_q <= 1'b0; inv_q <= 1'b0; inexact_q <= c_mag_nz;
                out_valid_q <= 1'b1; state <= DONE;
              end
              OVF: begin
                // -2^31 is the one in-range value with exponent 158.
                y_q <= c_sign ? INT_MIN : INT_MAX;
                ovf_q <= ~c_is_int_min; inv_q <= 1'b0; inexact_q <= 1'b0;
                out_valid_q <= 1'b1; state <= DONE;
              end
              default: state <= SHIFT;
            endcase
          end
        end
        SHIFT: begin
          m      <= m_next;
          cnt    <= cnt_next;
          sticky <= sticky | lost;
          if (cnt_next == 5'd0) begin
            y_q         <= sign_q ? (~m_next + 32'd1) : m_next;
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
            inexact_q   <= sticky | lost;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.inv       = inv_q;
  assign bus.inexact   = inexact_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_fp32_to_int32.sv
// Scoreboarded bench for fp32_to_int32 at STEP=1 and STEP=4: directed vectors,
// latency, backpressure, busy-input and mid-operation reset.
module tb_fp32_to_int32;
  import fp32_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] y;
    logic [2:0]  fl;   // {ovf, inv, inexact}
    logic [7:0]  lat;  // 0 = latency not checked
  } vec_t;

  typedef struct packed {
    logic [31:0] y;
    logic [2:0]  fl;
    logic [7:0]  lat;
    logic [31:0] acc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fp32_to_int32_if bus1 ();
  fp32_to_int32_if bus4 ();
  state_t state1, state4;

  fp32_to_int32 #(.STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(state1));
  fp32_to_int32 #(.STEP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .state_dbg(state4));

  // ---------------- scoreboard ----------------
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic seen [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_cycle(input int sel, input logic ov, input logic ordy, input logic ir,
                           input logic [31:0] y, input logic [2:0] fl);
    exp_t e;
    int   qs;
    if (!ov) return;
    qs = (sel == 0) ? exp_q0.size() : exp_q1.size();
    if (qs == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL dut%0d unexpected_output: y=%h flags=%b with nothing pending", sel, y, fl);
      return;
    end
    e = (sel == 0) ? exp_q0[0] : exp_q1[0];
    if (!seen[sel]) begin
      seen[sel] = 1'b1;
      if (e.lat != 8'd0) chk($sformatf("dut%0d latency", sel), 32'(cyc) - e.acc + 32'd1, 32'(e.lat));
    end
    chk($sformatf("dut%0d y", sel), y, e.y);
    chk($sformatf("dut%0d flags", sel), {29'b0, fl}, {29'b0, e.fl});
    chk($sformatf("dut%0d in_ready_busy", sel), {31'b0, ir}, 32'd0);
    if (ordy) begin
      if (sel == 0) void'(exp_q0.pop_front());
      else          void'(exp_q1.pop_front());
      seen[sel] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen[0] = 1'b0;
      seen[1] = 1'b0;
    end else begin
      mon_cycle(0, bus1.out_valid, bus1.out_ready, bus1.in_ready, bus1.y,
                {bus1.ovf, bus1.inv, bus1.inexact});
      mon_cycle(1, bus4.out_valid, bus4.out_ready, bus4.in_ready, bus4.y,
                {bus4.ovf, bus4.inv, bus4.inexact});
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int sel, input vec_t v);
    exp_t e;
    bit   ok;
    e.y = v.y; e.fl = v.fl; e.lat = v.lat; e.acc = '0;
    if (sel == 0) begin bus1.a = v.a; bus1.in_valid = 1'b1; end
    else          begin bus4.a = v.a; bus4.in_valid = 1'b1; end
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if ((sel == 0) ? bus1.in_ready : bus4.in_ready) begin
        ok = 1'b1;
        e.acc = 32'(cyc + 1);
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
      end
      @(negedge clk);
    end
    if (sel == 0) bus1.in_valid = 1'b0;
    else          bus4.in_valid = 1'b0;
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL dut%0d accept_timeout: a=%h never accepted", sel, v.a);
    end
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d drain_pending", sel),
        32'((sel == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  vec_t v1 [18];
  vec_t v4 [5];

  initial begin
    v1 = '{
      '{32'h3F800000, 32'h00000001, 3'b000, 8'd24},  // 1.0
      '{32'hC0200000, 32'hFFFFFFFE, 3'b001, 8'd23},  // -2.5
      '{32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 8'd8},   // left shift 7
      '{32'h4F000000, 32'h7FFFFFFF, 3'b100, 8'd1},   // 2^31
      '{32'hCF000000, 32'h80000000, 3'b000, 8'd1},   // -2^31 exact
      '{32'h7FC00000, 32'h7FFFFFFF, 3'b010, 8'd1},   // qNaN
      '{32'hFF800000, 32'h80000000, 3'b100, 8'd1},   // -inf
      '{32'h3F000000, 32'h00000000, 3'b001, 8'd1},   // 0.5
      '{32'h80000000, 32'h00000000, 3'b000, 8'd1},   // -0.0
      '{32'h00000000, 32'h00000000, 3'b000, 8'd1},   // +0.0
      '{32'h7F800000, 32'h7FFFFFFF, 3'b100, 8'd1},   // +inf
      '{32'h3FC00000, 32'h00000001, 3'b001, 8'd24},  // 1.5
      '{32'h447A0000, 32'h000003E8, 3'b000, 8'd15},  // 1000.0
      '{32'hCEFFFFFF, 32'h80000080, 3'b000, 8'd8},   // -(2^31-128)
      '{32'h4B000000, 32'h00800000, 3'b000, 8'd0},   // 2^23, zero shift
      '{32'hCB7FFFFF, 32'hFF000001, 3'b000, 8'd0},   // -(2^24-1)
      '{32'hFFC00001, 32'h7FFFFFFF, 3'b010, 8'd1},   // negative NaN
      '{32'hCF000001, 32'h80000000, 3'b100, 8'd1}    // just below -2^31
    };
    v4 = '{
      '{32'h3F800000, 32'h00000001, 3'b000, 8'd7},
      '{32'hC0200000, 32'hFFFFFFFE, 3'b001, 8'd7},
      '{32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 8'd3},
      '{32'h447A0000, 32'h000003E8, 3'b000, 8'd5},
      '{32'h4F000000, 32'h7FFFFFFF, 3'b100, 8'd1}
    };
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset y", bus1.y, 32'd0);
    chk("reset out_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("reset flags", {29'b0, bus1.ovf, bus1.inv, bus1.inexact}, 32'd0);
    chk("reset state", 32'(state1), 32'(IDLE));
    chk("reset y4", bus4.y, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", {31'b0, bus1.in_ready}, 32'd1);
    chk("in_ready4 after reset", {31'b0, bus4.in_ready}, 32'd1);

    foreach (v1[i]) send(0, v1[i]);
    drain(0);
    foreach (v4[i]) send(1, v4[i]);
    drain(1);

    // Backpressure in DONE, with a competing operand offered while busy.
    bus1.out_ready = 1'b0;
    send(0, '{32'h3F000000, 32'h00000000, 3'b001, 8'd1});
    n = 0;
    while (!bus1.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp out_valid_reached", {31'b0, bus1.out_valid}, 32'd1);
    bus1.a = 32'h3F800000;
    bus1.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp out_valid_held", {31'b0, bus1.out_valid}, 32'd1);
    chk("bp state_done", 32'(state1), 32'(DONE));
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    drain(0);
    repeat (30) @(negedge clk);

    // Reset in the middle of a long conversion.
    send(0, '{32'h3F800000, 32'h00000001, 3'b000, 8'd24});
    repeat (5) @(negedge clk);
    chk("mid state_shift", 32'(state1), 32'(SHIFT));
    rst_n = 1'b0;
    #1;
    exp_q0.delete();
    chk("mid_rst out_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("mid_rst y", bus1.y, 32'd0);
    chk("mid_rst state", 32'(state1), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst out_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("post_rst in_ready", {31'b0, bus1.in_ready}, 32'd1);

    // Converter still works after the aborted operation.
    send(0, '{32'hC0200000, 32'hFFFFFFFE, 3'b001, 8'd23});
    drain(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
